// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types, defaults and counter helpers for the BTB controller
package btb_pkg;

  localparam int IDX_W_DEF = 10;
  localparam int TAG_W_DEF = 32 - IDX_W_DEF - 2;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef logic [1:0] ctr_t;

  localparam ctr_t WEAK_NT = 2'b01;
  localparam ctr_t WEAK_T  = 2'b10;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_sweep_cnt.sv
// rtl/btb_sweep_cnt.sv - scrub index counter with restart and last-index done pulse
module btb_sweep_cnt
  import btb_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             restart_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             done_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (restart_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign done_o = en_i && !restart_i && (idx_q == '1);

endmodule

// File: rtl/btb_ctrl.sv
// rtl/btb_ctrl.sv - BTB valid/policy controller: lookup, update writes, storage scrub sweep
// Define BTB_COUNTER_EN for 2-bit direction counters; otherwise a hit always predicts taken.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [31:0]      pc_if_i,
  input  logic [TAG_W-1:0] btb_tag_i,
  input  logic [31:0]      btb_target_i,
  output logic             pred_hit_o,
  output logic             pred_taken_o,
  output logic [31:0]      pred_pc_o,
  input  logic             ex_valid_i,
  input  logic             ex_taken_i,
  input  logic             ex_hit_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_target_i,
  output logic             btb_we_o,
  output logic [IDX_W-1:0] btb_widx_o,
  output logic [TAG_W-1:0] btb_wtag_o,
  output logic [31:0]      btb_wdata_o,
  output logic             busy_o
);

  localparam int N = 1 << IDX_W;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_done;
  logic [N-1:0]     valid_q;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             run, upd, lookup_hit, lookup_taken;
  logic             unused_pc_bits;

  assign if_idx = pc_if_i[IDX_W+1:2];
  assign if_tag = pc_if_i[31:IDX_W+2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];
  assign ex_tag = ex_pc_i[31:IDX_W+2];
  assign unused_pc_bits = ^{pc_if_i[1:0], ex_pc_i[1:0]};

  assign run = (state_q == RUN);
  // flush takes priority over any resolution arriving on the same edge
  assign upd = run && !flush_i && ex_valid_i;

  btb_sweep_cnt #(.IDX_W(IDX_W)) u_sweep (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .restart_i(flush_i),
    .en_i     (state_q == SWEEP),
    .idx_o    (sweep_idx),
    .done_o   (sweep_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SWEEP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = SWEEP;
    end else if (state_q == SWEEP && sweep_done) begin
      state_d = RUN;
    end
  end

  assign lookup_hit = run && valid_q[if_idx] && (btb_tag_i == if_tag);

`ifdef BTB_COUNTER_EN
  ctr_t cnt_q [N];

  assign lookup_taken = lookup_hit && cnt_q[if_idx][1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '{default: WEAK_NT};
    end else if (flush_i) begin
      cnt_q <= '{default: WEAK_NT};
    end else if (upd) begin
      if (ex_taken_i) begin
        cnt_q[ex_idx] <= ex_hit_i ? ctr_inc(cnt_q[ex_idx]) : WEAK_T;
      end else if (ex_hit_i) begin
        cnt_q[ex_idx] <= ctr_dec(cnt_q[ex_idx]);
      end
    end
  end
`else
  assign lookup_taken = lookup_hit;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd) begin
      if (ex_taken_i) begin
        valid_q[ex_idx] <= 1'b1;
`ifndef BTB_COUNTER_EN
      end else if (ex_hit_i) begin
        valid_q[ex_idx] <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    pred_hit_o   = lookup_hit;
    pred_taken_o = lookup_taken;
    pred_pc_o    = lookup_taken ? btb_target_i : pc_if_i + 32'd4;
    busy_o       = (state_q == SWEEP);
    btb_we_o     = 1'b0;
    btb_widx_o   = ex_idx;
    btb_wtag_o   = ex_tag;
    btb_wdata_o  = ex_target_i;
    if (flush_i) begin
      btb_we_o    = 1'b1;
      btb_widx_o  = '0;
      btb_wtag_o  = '0;
      btb_wdata_o = '0;
    end else if (state_q == SWEEP) begin
      btb_we_o    = 1'b1;
      btb_widx_o  = sweep_idx;
      btb_wtag_o  = '0;
      btb_wdata_o = '0;
    end else if (upd && ex_taken_i) begin
      btb_we_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// tb/tb_btb_ctrl.sv - self-checking bench for btb_ctrl (directed table plus randomized model check)
module tb_btb_ctrl;

  localparam int IDX_W = 10;
  localparam int TAG_W = 20;
  localparam int N     = 1024;
`ifdef BTB_COUNTER_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush;
  logic [31:0]      pc_if, btb_target, ex_pc, ex_target;
  logic [TAG_W-1:0] btb_tag;
  logic             ex_valid, ex_taken, ex_hit;
  logic             hit, taken, we, busy;
  logic [31:0]      pred_pc, wdata;
  logic [IDX_W-1:0] widx;
  logic [TAG_W-1:0] wtag;

  always #5 clk = ~clk;

  btb_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .pc_if_i(pc_if), .btb_tag_i(btb_tag), .btb_target_i(btb_target),
    .pred_hit_o(hit), .pred_taken_o(taken), .pred_pc_o(pred_pc),
    .ex_valid_i(ex_valid), .ex_taken_i(ex_taken), .ex_hit_i(ex_hit),
    .ex_pc_i(ex_pc), .ex_target_i(ex_target),
    .btb_we_o(we), .btb_widx_o(widx), .btb_wtag_o(wtag), .btb_wdata_o(wdata),
    .busy_o(busy)
  );

  int errors = 0;
  int checks = 0;

  // reference model: controller state plus the storage contents it should have written
  bit          m_sweep;
  int          m_idx;
  bit          m_valid [N];
  int          m_ctr   [N];
  logic [19:0] s_tag   [N];
  logic [31:0] s_tgt   [N];

  typedef struct {
    logic [31:0] pc;   logic [19:0] btag; logic [31:0] btgt;
    logic        exv;  logic        ext;  logic        exh;
    logic [31:0] expc; logic [31:0] extgt;
    logic        e_hit; logic       e_tkn; logic [31:0] e_pc;
    logic        e_we; logic [9:0]  e_widx; logic [19:0] e_wtag; logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction

  function automatic logic [19:0] tag_of(input logic [31:0] pc);
    return 20'(pc / 32'h1000);
  endfunction

  task automatic model_reset();
    m_sweep = 1'b1;
    m_idx   = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic check_model();
    int i;
    bit h, t;
    i = idx_of(pc_if);
    h = !m_sweep && m_valid[i] && (btb_tag == tag_of(pc_if));
    t = h && (!CNT || m_ctr[i] >= 2);
    chk("busy", 32'(busy), 32'(m_sweep));
    chk("hit", 32'(hit), 32'(h));
    chk("taken", 32'(taken), 32'(t));
    chk("pred_pc", pred_pc, t ? btb_target : pc_if + 32'd4);
    if (flush || m_sweep) begin
      chk("we", 32'(we), 32'd1);
      chk("widx", 32'(widx), flush ? 32'd0 : 32'(m_idx));
      chk("wtag", 32'(wtag), 32'd0);
      chk("wdata", wdata, 32'd0);
    end else if (ex_valid && ex_taken) begin
      chk("we", 32'(we), 32'd1);
      chk("widx", 32'(widx), 32'(idx_of(ex_pc)));
      chk("wtag", 32'(wtag), 32'(tag_of(ex_pc)));
      chk("wdata", wdata, ex_target);
    end else begin
      chk("we", 32'(we), 32'd0);
    end
  endtask

  task automatic model_step();
    int e;
    if (flush) begin
      model_reset();
      s_tag[0] = '0;
      s_tgt[0] = '0;
    end else if (m_sweep) begin
      s_tag[m_idx] = '0;
      s_tgt[m_idx] = '0;
      m_idx++;
      if (m_idx == N) begin
        m_sweep = 1'b0;
        m_idx   = 0;
      end
    end else if (ex_valid) begin
      e = idx_of(ex_pc);
      if (ex_taken) begin
        s_tag[e]   = tag_of(ex_pc);
        s_tgt[e]   = ex_target;
        m_valid[e] = 1'b1;
        if (CNT) m_ctr[e] = ex_hit ? ((m_ctr[e] < 3) ? m_ctr[e] + 1 : 3) : 2;
      end else if (ex_hit) begin
        if (CNT) m_ctr[e] = (m_ctr[e] > 0) ? m_ctr[e] - 1 : 0;
        else     m_valid[e] = 1'b0;
      end
    end
  endtask

  task automatic rnd_inputs(input bit allow_flush);
    int ii, tt;
    ii = $urandom_range(0, 7);
    tt = $urandom_range(0, 3);
    pc_if      = (32'(tt) << 12) | (32'(ii) << 2);
    btb_tag    = ($urandom_range(0, 7) == 0) ? 20'($urandom) : s_tag[ii];
    btb_target = s_tgt[ii];
    ex_valid   = 1'($urandom_range(0, 1));
    ex_taken   = 1'($urandom_range(0, 1));
    ex_hit     = 1'($urandom_range(0, 1));
    ex_pc      = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
    ex_target  = $urandom;
    flush      = allow_flush && ($urandom_range(0, 399) == 0);
  endtask

  task automatic rnd_cycle(input bit allow_flush);
    rnd_inputs(allow_flush);
    #3;
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_we"}, 32'(we), 32'd1);
    chk({tag, "_widx"}, 32'(widx), 32'd0);
    chk({tag, "_wtag"}, 32'(wtag), 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_hit"}, 32'(hit), 32'd0);
    chk({tag, "_taken"}, 32'(taken), 32'd0);
    chk({tag, "_pc"}, pred_pc, pc_if + 32'd4);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    pc_if = v.pc; btb_tag = v.btag; btb_target = v.btgt;
    ex_valid = v.exv; ex_taken = v.ext; ex_hit = v.exh;
    ex_pc = v.expc; ex_target = v.extgt; flush = 1'b0;
    #3;
    chk($sformatf("v%0d_hit", k), 32'(hit), 32'(v.e_hit));
    chk($sformatf("v%0d_taken", k), 32'(taken), 32'(v.e_tkn));
    chk($sformatf("v%0d_pc", k), pred_pc, v.e_pc);
    chk($sformatf("v%0d_we", k), 32'(we), 32'(v.e_we));
    if (v.e_we) begin
      chk($sformatf("v%0d_widx", k), 32'(widx), 32'(v.e_widx));
      chk($sformatf("v%0d_wtag", k), 32'(wtag), 32'(v.e_wtag));
      chk($sformatf("v%0d_wdata", k), wdata, v.e_wdata);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int busy_cycles;

    // fresh entries only: hit/taken sequences for one index, wrap-around pc, counter walk
    tbl[0]  = '{32'h0, 20'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h4, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[1]  = '{32'h1004, 20'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h2000,
                1'b0, 1'b0, 32'h1008, 1'b1, 10'h1, 20'h1, 32'h2000};
    tbl[2]  = '{32'h1004, 20'h1, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b1, 32'h2000, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[3]  = '{32'h2004, 20'h1, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h2008, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[4]  = '{32'h1004, 20'h1, 32'h2000, 1'b1, 1'b0, 1'b1, 32'h1004, 32'h0,
                1'b1, 1'b1, 32'h2000, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[5]  = '{32'h1004, 20'h1, 32'h2000, 1'b1, 1'b0, 1'b1, 32'h1004, 32'h0,
                CNT, 1'b0, 32'h1008, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[6]  = '{32'h1004, 20'h1, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                CNT, 1'b0, 32'h1008, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[7]  = '{32'h1004, 20'h1, 32'h2000, 1'b1, 1'b1, 1'b1, 32'h1004, 32'h3000,
                CNT, 1'b0, 32'h1008, 1'b1, 10'h1, 20'h1, 32'h3000};
    tbl[8]  = '{32'h1004, 20'h1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, !CNT, CNT ? 32'h1008 : 32'h3000, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[9]  = '{32'hFFFF_FFFC, 20'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[10] = '{32'hFFFF_FFFC, 20'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h100,
                1'b0, 1'b0, 32'h0, 1'b1, 10'h3FF, 20'hFFFFF, 32'h100};
    tbl[11] = '{32'hFFFF_FFFC, 20'hFFFFF, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b1, 32'h100, 1'b0, 10'h0, 20'h0, 32'h0};
    tbl[12] = '{32'h1008, 20'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h100C, 1'b0, 10'h0, 20'h0, 32'h0};

    for (int i = 0; i < N; i++) begin
      s_tag[i] = '0;
      s_tgt[i] = '0;
    end
    rst_n = 1'b0; flush = 1'b0;
    pc_if = 32'h10; btb_tag = '0; btb_target = 32'h0;
    ex_valid = 1'b1; ex_taken = 1'b1; ex_hit = 1'b0; ex_pc = 32'h1004; ex_target = 32'h2000;
    model_reset();
    #1 check_reset("rst");
    pc_if = 32'hFFFF_FFFC;
    #1 check_reset("rst_wrap");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // flush with a concurrent taken resolution at sweep index 500
    repeat (500) rnd_cycle(1'b0);
    pc_if = 32'h1004; btb_tag = '0; btb_target = 32'h0;
    flush = 1'b1; ex_valid = 1'b1; ex_taken = 1'b1; ex_hit = 1'b0;
    ex_pc = 32'h1004; ex_target = 32'h2000;
    #3;
    check_model();
    @(posedge clk);
    model_step();
    #1 flush = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < N + 50 && busy; c++) begin
      busy_cycles++;
      rnd_cycle(1'b0);
    end
    chk("flush_sweep_len", 32'(busy_cycles), 32'(N));

    for (int k = 0; k < 13; k++) run_vec(k, tbl[k]);

    repeat (3000) rnd_cycle(1'b1);

    // asynchronous reset in the middle of RUN with live entries
    for (int c = 0; c < N + 10 && m_sweep; c++) rnd_cycle(1'b0);
    repeat (40) rnd_cycle(1'b0);
    ex_valid = 1'b1; ex_taken = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("mid_rst");
    @(posedge clk);
    #1 check_reset("mid_rst_hold");
    rst_n = 1'b1;
    repeat (N + 60) rnd_cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
